// File: rtl/rs_issue_sched_if.sv
// Bus between the reservation station and the issue scheduler.
// Handshake: fu_busy[f] is the inverted ready of FU f; a grant (issue_valid[f]) is only formed on a cycle where fu_busy[f] was low.
interface rs_issue_sched_if;
  logic        en;
  logic        flush;
  logic [15:0] row_ready;
  logic [31:0] row_fu;
  logic [2:0]  fu_busy;
  logic [2:0]  issue_valid;
  logic [3:0]  issue_row_0;
  logic [3:0]  issue_row_1;
  logic [3:0]  issue_row_2;
  logic [15:0] row_clear;
  logic        bad_fu_err;
  logic [11:0] dbg_rr_ptr;

  modport master (
    output en, flush, row_ready, row_fu, fu_busy,
    input  issue_valid, issue_row_0, issue_row_1, issue_row_2, row_clear,
           bad_fu_err, dbg_rr_ptr
  );

  modport slave (
    input  en, flush, row_ready, row_fu, fu_busy,
    output issue_valid, issue_row_0, issue_row_1, issue_row_2, row_clear,
           bad_fu_err, dbg_rr_ptr
  );
endinterface

// File: rtl/rs_issue_sched.sv
// Per-FU round-robin issue selection from a 16-row reservation station.
// Grants are registered; granted rows are masked for one cycle while the RS clears them.
module rs_issue_sched #(
  parameter int NUM_ROWS = 16,
  parameter int NUM_FU   = 3
) (
  input logic              clk,
  input logic              rst,
  rs_issue_sched_if.slave  bus
);

  logic [3:0]          rr_ptr [NUM_FU];
  logic [3:0]          issue_row_q [NUM_FU];
  logic [NUM_FU-1:0]   issue_valid_q;
  logic [NUM_ROWS-1:0] row_clear_q;
  logic [NUM_ROWS-1:0] inflight_mask;
  logic                bad_fu_q;
  logic                armed;

  logic [NUM_ROWS-1:0] cand [NUM_FU];
  logic [NUM_FU-1:0]   gnt_valid;
  logic [3:0]          gnt_row [NUM_FU];
  logic [NUM_ROWS-1:0] gnt_vec;
  logic [3:0]          idx;
  logic                bad_seen;

  always_comb begin
    gnt_valid = '0;
    gnt_vec   = '0;
    bad_seen  = 1'b0;
    idx       = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      cand[f]    = '0;
      gnt_row[f] = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        cand[f][r] = bus.row_ready[r] && (bus.row_fu[2*r +: 2] == 2'(f))
                     && !inflight_mask[r];
      end
      // armed keeps the first post-reset edge grant-free
      if (bus.fu_busy[f] || !bus.en || !armed) cand[f] = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        idx = rr_ptr[f] + 4'(i);
        if (!gnt_valid[f] && cand[f][idx]) begin
          gnt_valid[f] = 1'b1;
          gnt_row[f]   = idx;
        end
      end
      if (gnt_valid[f]) gnt_vec[gnt_row[f]] = 1'b1;
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (bus.row_ready[r] && (bus.row_fu[2*r +: 2] == 2'd3)) bad_seen = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_q <= '0;
      row_clear_q   <= '0;
      inflight_mask <= '0;
      bad_fu_q      <= 1'b0;
      armed         <= 1'b0;
      for (int f = 0; f < NUM_FU; f++) begin
        rr_ptr[f]      <= '0;
        issue_row_q[f] <= '0;
      end
    end else begin
      armed <= 1'b1;
      if (bad_seen) bad_fu_q <= 1'b1;
      if (bus.flush) begin
        issue_valid_q <= '0;
        row_clear_q   <= '0;
        inflight_mask <= '0;
      end else begin
        issue_valid_q <= gnt_valid;
        row_clear_q   <= gnt_vec;
        inflight_mask <= gnt_vec;
        for (int f = 0; f < NUM_FU; f++) begin
          if (gnt_valid[f]) begin
            issue_row_q[f] <= gnt_row[f];
            rr_ptr[f]      <= gnt_row[f] + 4'd1;
          end
        end
      end
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_row_0 = issue_row_q[0];
  assign bus.issue_row_1 = issue_row_q[1];
  assign bus.issue_row_2 = issue_row_q[2];
  assign bus.row_clear   = row_clear_q;
  assign bus.bad_fu_err  = bad_fu_q;
  assign bus.dbg_rr_ptr  = {rr_ptr[2], rr_ptr[1], rr_ptr[0]};

endmodule

// File: tb/tb_rs_issue_sched.sv
// Vector-table bench for rs_issue_sched with an expected-output queue.
module tb_rs_issue_sched;

  logic clk;
  logic rst;
  rs_issue_sched_if bus();

  rs_issue_sched #(.NUM_ROWS(16), .NUM_FU(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        flush;
    logic [15:0] rdy;
    logic [31:0] fu;
    logic [2:0]  busy;
    logic [2:0]  v;
    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [15:0] clr;
    logic        err;
    logic [11:0] ptr;
  } vec_t;

  // packed as {issue_valid, row_0, row_1, row_2, row_clear, bad_fu_err, rr_ptr{2,1,0}}
  logic [43:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[21];

  function automatic vec_t mk(input logic e, input logic fl, input logic [15:0] rdy,
                              input logic [31:0] fu, input logic [2:0] busy,
                              input logic [2:0] v, input logic [3:0] r0,
                              input logic [3:0] r1, input logic [3:0] r2,
                              input logic [15:0] clr, input logic err,
                              input logic [11:0] ptr);
    vec_t t;
    t.en = e; t.flush = fl; t.rdy = rdy; t.fu = fu; t.busy = busy;
    t.v = v; t.r0 = r0; t.r1 = r1; t.r2 = r2; t.clr = clr; t.err = err; t.ptr = ptr;
    return t;
  endfunction

  // driver: apply inputs for one cycle, check outputs just after the edge
  task automatic apply(input logic r, input logic e, input logic fl,
                       input logic [15:0] rdy, input logic [31:0] fu,
                       input logic [2:0] busy, input logic [43:0] expv,
                       input string name);
    logic [43:0] got;
    logic [43:0] want;
    rst           = r;
    bus.en        = e;
    bus.flush     = fl;
    bus.row_ready = rdy;
    bus.row_fu    = fu;
    bus.fu_busy   = busy;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    got = {bus.issue_valid, bus.issue_row_0, bus.issue_row_1, bus.issue_row_2,
           bus.row_clear, bus.bad_fu_err, bus.dbg_rr_ptr};
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got v=%b rows=%h/%h/%h clr=%h err=%b ptr=%h, expected v=%b rows=%h/%h/%h clr=%h err=%b ptr=%h",
               name, got[43:41], got[40:37], got[36:33], got[32:29], got[28:13], got[12], got[11:0],
               want[43:41], want[40:37], want[36:33], want[32:29], want[28:13], want[12], want[11:0]);
    end
  endtask

  initial begin
    vecs[0]  = mk(1,0,16'h0005,32'h0,3'b000, 3'b000,4'h0,4'h0,4'h0,16'h0000,0,12'h000);
    vecs[1]  = mk(1,0,16'h0005,32'h0,3'b000, 3'b001,4'h0,4'h0,4'h0,16'h0001,0,12'h001);
    vecs[2]  = mk(1,0,16'h0005,32'h0,3'b000, 3'b001,4'h2,4'h0,4'h0,16'h0004,0,12'h003);
    vecs[3]  = mk(1,0,16'h0005,32'h0,3'b000, 3'b001,4'h0,4'h0,4'h0,16'h0001,0,12'h001);
    vecs[4]  = mk(1,0,16'h0000,32'h0,3'b000, 3'b000,4'h0,4'h0,4'h0,16'h0000,0,12'h001);
    vecs[5]  = mk(1,0,16'h0288,32'h0008_4000,3'b000, 3'b111,4'h3,4'h7,4'h9,16'h0288,0,12'hA84);
    vecs[6]  = mk(1,0,16'h0000,32'h0,3'b000, 3'b000,4'h3,4'h7,4'h9,16'h0000,0,12'hA84);
    vecs[7]  = mk(1,0,16'h2000,32'h0,3'b000, 3'b001,4'hD,4'h7,4'h9,16'h2000,0,12'hA8E);
    vecs[8]  = mk(1,0,16'h8002,32'h0,3'b000, 3'b001,4'hF,4'h7,4'h9,16'h8000,0,12'hA80);
    vecs[9]  = mk(1,0,16'h8002,32'h0,3'b000, 3'b001,4'h1,4'h7,4'h9,16'h0002,0,12'hA82);
    vecs[10] = mk(1,0,16'h0000,32'h0,3'b000, 3'b000,4'h1,4'h7,4'h9,16'h0000,0,12'hA82);
    vecs[11] = mk(1,0,16'h0030,32'h0000_0100,3'b010, 3'b001,4'h5,4'h7,4'h9,16'h0020,0,12'hA86);
    vecs[12] = mk(1,0,16'h0030,32'h0000_0100,3'b000, 3'b010,4'h5,4'h4,4'h9,16'h0010,0,12'hA56);
    vecs[13] = mk(1,0,16'h0000,32'h0,3'b000, 3'b000,4'h5,4'h4,4'h9,16'h0000,0,12'hA56);
    vecs[14] = mk(1,0,16'h0040,32'h0000_3000,3'b000, 3'b000,4'h5,4'h4,4'h9,16'h0000,1,12'hA56);
    vecs[15] = mk(1,0,16'h0040,32'h0000_3000,3'b000, 3'b000,4'h5,4'h4,4'h9,16'h0000,1,12'hA56);
    vecs[16] = mk(1,0,16'h0000,32'h0,3'b000, 3'b000,4'h5,4'h4,4'h9,16'h0000,1,12'hA56);
    vecs[17] = mk(0,0,16'h0001,32'h0,3'b000, 3'b000,4'h5,4'h4,4'h9,16'h0000,1,12'hA56);
    vecs[18] = mk(1,0,16'h0001,32'h0,3'b000, 3'b001,4'h0,4'h4,4'h9,16'h0001,1,12'hA51);
    vecs[19] = mk(1,1,16'h0004,32'h0,3'b000, 3'b000,4'h0,4'h4,4'h9,16'h0000,1,12'hA51);
    vecs[20] = mk(1,0,16'h0004,32'h0,3'b000, 3'b001,4'h2,4'h4,4'h9,16'h0004,1,12'hA53);

    // reset state
    apply(1, 0, 0, 16'h0, 32'h0, 3'b000, 44'h0, "reset_0");
    apply(1, 1, 0, 16'hFFFF, 32'h0, 3'b000, 44'h0, "reset_1");

    for (int i = 0; i < 21; i++) begin
      apply(0, vecs[i].en, vecs[i].flush, vecs[i].rdy, vecs[i].fu, vecs[i].busy,
            {vecs[i].v, vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].clr,
             vecs[i].err, vecs[i].ptr},
            $sformatf("vec_%0d", i));
    end

    // reset in the middle of a grant stream
    apply(0, 1, 0, 16'h0001, 32'h0, 3'b000,
          {3'b001, 4'h0, 4'h4, 4'h9, 16'h0001, 1'b1, 12'hA51}, "pre_rst_grant");
    apply(1, 1, 1, 16'h0001, 32'h0, 3'b000, 44'h0, "mid_rst");
    apply(0, 1, 0, 16'h0001, 32'h0, 3'b000, 44'h0, "post_rst_idle");
    apply(0, 1, 0, 16'h0001, 32'h0, 3'b000,
          {3'b001, 4'h0, 4'h0, 4'h0, 16'h0001, 1'b0, 12'h001}, "post_rst_grant");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 16, number of reservation-station rows; only 16 is supported.
REQ-002 SHALL have parameter NUM_FU, default 3, number of functional units, ids 0..2.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, pipeline enable; when low, no grants are issued and state is held.
REQ-006 SHALL have port flush, input, 1, discards pending grants.
REQ-007 SHALL have port row_ready, input, 16, bit r set = row r in use and both sources ready.
REQ-008 SHALL have port row_fu, input, 32, 2-bit FU id of row r at bits [2r+1:2r].
REQ-009 SHALL have port fu_busy, input, 3, bit f set = FU f cannot accept an instruction this cycle.
REQ-010 SHALL have port issue_valid, output, 3, bit f set = FU f granted a row.
REQ-011 SHALL have ports issue_row_0, issue_row_1 and issue_row_2, each an output of 4 bits, granted row index per FU.
REQ-012 SHALL have port row_clear, output, 16, one-hot-per-grant pulse telling the RS to free the granted rows.
REQ-013 SHALL have port bad_fu_err, output, 1, sticky flag: a ready row carried FU id 3.

Function
REQ-014 SHALL form candidates per FU f, each cycle: row_ready & (row_fu id == f) & ~inflight_mask, forced to zero if fu_busy[f] or !en.
REQ-015 SHALL select, per FU, the first candidate scanning upward from rr_ptr[f] with wrap 15->0; rows below rr_ptr[f] are reached only after the wrap.
REQ-016 SHALL register grants: issue_valid, issue_row_* and row_clear appear exactly one cycle after the candidate cycle.
REQ-017 SHALL grant at most one row per FU per cycle, and any one row to at most one FU.
REQ-018 SHALL hold issue_row_f at its previous value when issue_valid[f]=0; consumers ignore it.
REQ-019 SHALL set row_clear to the OR of the one-hot codes of all valid grants that cycle.
REQ-020 SHALL load inflight_mask with the same-cycle grant vector; granted rows are excluded from candidates in the following cycle, covering the RS clear latency.
REQ-021 SHALL update rr_ptr[f] to (granted row + 1) mod 16 on a grant to FU f, and hold it otherwise.
REQ-022 SHALL never grant a ready row whose FU id is 3, and SHALL set bad_fu_err for it; bad_fu_err stays set until rst.
REQ-023 SHALL, on flush, zero issue_valid, row_clear and inflight_mask on the next edge; rr_ptr is retained.
REQ-024 SHALL let flush override en and any same-cycle candidates.
REQ-025 SHALL hold issue_valid at 0 and leave rr_ptr unchanged while en=0, even with ready rows.
REQ-026 SHALL not issue, while fu_busy[f]=1, to FU f; other FUs proceed independently.

Reset
REQ-027 SHALL, on the edge where rst=1: issue_valid=0, issue_row_*=0, row_clear=0, inflight_mask=0, every rr_ptr=0, bad_fu_err=0.
REQ-028 SHALL give rst precedence over flush and en; a reset mid-grant drops that grant without any row_clear.
REQ-029 SHALL issue the first grant no earlier than the second edge after rst deasserts.

Verification
REQ-030 SHALL be verified: after reset, row_ready=0x0005, both rows FU0 -> cycle+1 issue_valid=001, issue_row_0=0, row_clear=0x0001; then with rows held ready -> row 2 granted, row 0 masked.
REQ-031 SHALL be verified: rows 3,7,9 ready with FU ids 0,1,2 -> issue_valid=111, rows 3/7/9, row_clear=0x0288.
REQ-032 SHALL be verified: rr_ptr[0]=14, rows 1 and 15 ready FU0 -> row 15 granted, then row 1 (wrap), rr_ptr[0]=2.
REQ-033 SHALL be verified: fu_busy=010, rows 4 (FU1) and 5 (FU0) ready -> only row 5 granted; dropping fu_busy next cycle -> row 4 granted.
REQ-034 SHALL be verified: row 6 ready with FU id 3 -> never granted, bad_fu_err=1 and it persists until rst.
REQ-035 SHALL be verified: flush coincident with a ready row -> issue_valid=0 and row_clear=0 next cycle; rst mid-stream -> all outputs 0 on the following edge.
